// File: rtl/chase_tp_scheduler_if.sv
`default_nettype none
// chase_tp_scheduler_if: job control, decoder issue/result and winner-select signals. Rev 1.0
interface chase_tp_scheduler_if #(
   parameter int METRIC_W = 12
);
   logic                i_mode;
   logic                i_start;
   logic                o_busy;
   logic                o_tp_issue;
   logic [2:0]          o_tp_id;
   logic                i_dec_ready;
   logic                i_dec_done;
   logic                i_dec_fail;
   logic [METRIC_W-1:0] i_dec_metric;
   logic [2:0]          o_select_tp;
   logic                o_sel_valid;
   logic                o_all_fail;
   logic                o_timeout;

   modport slave (
      input  i_mode, i_start, i_dec_ready, i_dec_done, i_dec_fail, i_dec_metric,
      output o_busy, o_tp_issue, o_tp_id, o_select_tp, o_sel_valid, o_all_fail, o_timeout
   );

   modport master (
      output i_mode, i_start, i_dec_ready, i_dec_done, i_dec_fail, i_dec_metric,
      input  o_busy, o_tp_issue, o_tp_id, o_select_tp, o_sel_valid, o_all_fail, o_timeout
   );
endinterface
`default_nettype wire

// File: rtl/chase_tp_scheduler.sv
`default_nettype none
// chase_tp_scheduler: issues Chase test patterns to the shared decoder and selects the lowest-cost one. Rev 1.0
// Optional macro TP_EARLY_EXIT_EN: a clean zero-metric result stops further issues.
module chase_tp_scheduler #(
   parameter int NUM_TP    = 4,
   parameter int METRIC_W  = 12,
   parameter int TO_CYCLES = 1024
) (
   input  wire logic           i_clk,
   input  wire logic           i_rst_n,
   chase_tp_scheduler_if.slave bus
);
   localparam int WD_W = $clog2(TO_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      WAIT   = 2'd2,
      DECIDE = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [2:0]          n_tp_q, n_tp_d;
   logic [2:0]          issued_q, issued_d;
   logic [2:0]          returned_q, returned_d;
   logic [2:0]          best_id_q, best_id_d;
   logic [METRIC_W-1:0] best_metric_q, best_metric_d;
   logic [WD_W-1:0]     wd_q, wd_d;
   logic                early_q, early_d;
   logic                timeout_q, timeout_d;
   logic                busy_q, busy_d;
   logic                tp_issue_q, tp_issue_d;
   logic [2:0]          tp_id_q, tp_id_d;
   logic                sel_valid_q, sel_valid_d;
   logic [2:0]          select_tp_q, select_tp_d;
   logic                all_fail_q, all_fail_d;
   logic                acc_issue, acc_done;
   logic [2:0]          target;

   always_comb begin
      state_d       = state_q;
      n_tp_d        = n_tp_q;
      issued_d      = issued_q;
      returned_d    = returned_q;
      best_id_d     = best_id_q;
      best_metric_d = best_metric_q;
      wd_d          = wd_q;
      early_d       = early_q;
      timeout_d     = timeout_q;
      target        = n_tp_q;
      acc_issue     = tp_issue_q & bus.i_dec_ready;
      // A done with nothing outstanding is spurious and must not move any counter.
      acc_done      = (state_q == ISSUE || state_q == WAIT) && bus.i_dec_done &&
                      (returned_q != issued_q);

      case (state_q)
         IDLE: begin
            if (bus.i_start) begin
               n_tp_d        = bus.i_mode ? 3'(NUM_TP) : 3'd1;
               issued_d      = 3'd0;
               returned_d    = 3'd0;
               best_id_d     = 3'd0;
               best_metric_d = '1;
               wd_d          = '0;
               early_d       = 1'b0;
               timeout_d     = 1'b0;
               state_d       = ISSUE;
            end
         end
         ISSUE, WAIT: begin
            if (acc_issue) issued_d = issued_q + 3'd1;
            if (acc_done) begin
               returned_d = returned_q + 3'd1;
               if (!early_q && !bus.i_dec_fail && bus.i_dec_metric < best_metric_q) begin
                  best_id_d     = returned_q + 3'd1;
                  best_metric_d = bus.i_dec_metric;
               end
`ifdef TP_EARLY_EXIT_EN
               if (!early_q && !bus.i_dec_fail && bus.i_dec_metric == '0) begin
                  early_d       = 1'b1;
                  best_id_d     = returned_q + 3'd1;
                  best_metric_d = '0;
               end
`endif
            end
            if (acc_issue || acc_done) wd_d = '0;
            else if (issued_q != returned_q) wd_d = wd_q + 1'b1;
`ifdef TP_EARLY_EXIT_EN
            target = early_d ? issued_d : n_tp_q;
`else
            target = n_tp_q;
`endif
            if (wd_d == WD_W'(TO_CYCLES)) begin
               timeout_d = 1'b1;
               state_d   = DECIDE;
            end else if (returned_d == target) begin
               state_d = DECIDE;
            end else if (issued_d == target) begin
               state_d = WAIT;
            end
         end
         DECIDE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d      = (state_d != IDLE);
      tp_issue_d  = (state_d == ISSUE);
      tp_id_d     = (state_d == ISSUE) ? issued_d + 3'd1 : 3'd0;
      sel_valid_d = (state_d == DECIDE);
      // No clean candidate: report pattern 1 and flag the all-fail case.
      select_tp_d = (state_d != DECIDE) ? 3'd0 : ((best_id_d == 3'd0) ? 3'd1 : best_id_d);
      all_fail_d  = (state_d == DECIDE) && (best_id_d == 3'd0);
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q       <= IDLE;
         n_tp_q        <= 3'd0;
         issued_q      <= 3'd0;
         returned_q    <= 3'd0;
         best_id_q     <= 3'd0;
         best_metric_q <= '1;
         wd_q          <= '0;
         early_q       <= 1'b0;
         timeout_q     <= 1'b0;
         busy_q        <= 1'b0;
         tp_issue_q    <= 1'b0;
         tp_id_q       <= 3'd0;
         sel_valid_q   <= 1'b0;
         select_tp_q   <= 3'd0;
         all_fail_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         n_tp_q        <= n_tp_d;
         issued_q      <= issued_d;
         returned_q    <= returned_d;
         best_id_q     <= best_id_d;
         best_metric_q <= best_metric_d;
         wd_q          <= wd_d;
         early_q       <= early_d;
         timeout_q     <= timeout_d;
         busy_q        <= busy_d;
         tp_issue_q    <= tp_issue_d;
         tp_id_q       <= tp_id_d;
         sel_valid_q   <= sel_valid_d;
         select_tp_q   <= select_tp_d;
         all_fail_q    <= all_fail_d;
      end
   end

   assign bus.o_busy      = busy_q;
   assign bus.o_tp_issue  = tp_issue_q;
   assign bus.o_tp_id     = tp_id_q;
   assign bus.o_sel_valid = sel_valid_q;
   assign bus.o_select_tp = select_tp_q;
   assign bus.o_all_fail  = all_fail_q;
   assign bus.o_timeout   = timeout_q;
endmodule
`default_nettype wire

// File: tb/tb_chase_tp_scheduler.sv
`default_nettype none
// tb_chase_tp_scheduler: directed and randomized checks against a count-based scheduling model. Rev 1.0
module tb_chase_tp_scheduler;
   localparam int NTP = 4;
   localparam int MW  = 12;
   localparam int TO  = 40;

   logic clk;
   logic rst_n;
   chase_tp_scheduler_if #(.METRIC_W(MW)) bus ();

   chase_tp_scheduler #(.NUM_TP(NTP), .METRIC_W(MW), .TO_CYCLES(TO)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int done_cyc = 0;
   int obs_sel_cnt = 0;

   // Reference model: job progress as plain counts plus the list of returned results.
   logic          m_seen_rst = 1'b0;
   logic          m_active = 1'b0, m_decide = 1'b0, m_timeout = 1'b0, m_stop = 1'b0;
   int            m_n = 0, m_issued = 0, m_returned = 0, m_stall = 0, m_win = 0;
   logic          m_fail [1:4];
   logic [MW-1:0] m_met  [1:4];
   int            exp_sel = 0;
   logic          exp_af = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic pick_winner();
      int best = 0;
      logic [MW-1:0] bm = '1;
      int k = m_stop ? m_win : m_returned;
      for (int i = 1; i <= k; i++)
         if (!m_fail[i] && m_met[i] < bm) begin
            best = i;
            bm   = m_met[i];
         end
      exp_sel = (best == 0) ? 1 : best;
      exp_af  = (best == 0);
   endtask

   task automatic model_update();
      logic iss, dn, outstanding;
      cyc++;
      if (!rst_n) begin
         m_seen_rst = 1'b1;
         m_active = 1'b0; m_decide = 1'b0; m_timeout = 1'b0; m_stop = 1'b0;
         m_n = 0; m_issued = 0; m_returned = 0; m_stall = 0;
      end else if (m_decide) begin
         m_decide = 1'b0;
         m_active = 1'b0;
      end else if (!m_active) begin
         if (bus.i_start) begin
            m_active = 1'b1; m_timeout = 1'b0; m_stop = 1'b0;
            m_n = bus.i_mode ? NTP : 1;
            m_issued = 0; m_returned = 0; m_stall = 0; m_win = 0;
         end
      end else begin
         iss = (m_issued < m_n) && !m_stop && bus.i_dec_ready;
         dn = bus.i_dec_done && (m_returned < m_issued);
         outstanding = (m_issued > m_returned);
         if (dn) begin
            m_returned++;
            if (!m_stop) begin
               m_fail[m_returned] = bus.i_dec_fail;
               m_met[m_returned]  = bus.i_dec_metric;
`ifdef TP_EARLY_EXIT_EN
               if (!bus.i_dec_fail && bus.i_dec_metric == '0) begin
                  m_stop = 1'b1;
                  m_win  = m_returned;
               end
`endif
            end
         end
         if (iss) m_issued++;
         if (iss || dn) m_stall = 0;
         else if (outstanding) m_stall++;
         if (m_stall == TO) begin
            m_timeout = 1'b1;
            m_decide  = 1'b1;
         end else if (m_returned == (m_stop ? m_issued : m_n)) begin
            m_decide = 1'b1;
         end
         if (m_decide) pick_winner();
      end
   endtask

   task automatic compare_outputs();
      logic exp_issue;
      exp_issue = m_active && !m_decide && (m_issued < m_n) && !m_stop;
      check("busy", bus.o_busy, m_active);
      check("tp_issue", bus.o_tp_issue, exp_issue);
      if (exp_issue) check("tp_id", bus.o_tp_id, m_issued + 1);
      check("sel_valid", bus.o_sel_valid, m_decide);
      if (m_decide) begin
         check("select_tp", bus.o_select_tp, exp_sel);
         check("all_fail", bus.o_all_fail, exp_af);
      end
      check("timeout", bus.o_timeout, m_timeout);
      if (bus.o_sel_valid === 1'b1) obs_sel_cnt++;
   endtask

   // Single compare process: advance the model at the edge, check the DUT mid-cycle.
   initial begin
      forever begin
         @(posedge clk);
         model_update();
         @(negedge clk);
         if (m_seen_rst) compare_outputs();
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input logic mode);
      bus.i_mode  = mode;
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
   endtask

   task automatic do_done(input logic f, input logic [MW-1:0] m);
      bus.i_dec_done   = 1'b1;
      bus.i_dec_fail   = f;
      bus.i_dec_metric = m;
      done_cyc = cyc;
      tick();
      bus.i_dec_done = 1'b0;
      bus.i_dec_fail = 1'b0;
   endtask

   task automatic expect_sel(input string tag, input int id, input logic af);
      check({tag, "_valid"}, bus.o_sel_valid, 1);
      check({tag, "_id"}, bus.o_select_tp, id);
      check({tag, "_allfail"}, bus.o_all_fail, af);
      check({tag, "_latency"}, cyc - done_cyc, 1);
   endtask

   int rdy4 [8] = '{1, 0, 1, 0, 1, 0, 1, 0};
   int dn4  [8] = '{0, 1, 1, 0, 1, 0, 1, 1};
   int met4 [8] = '{0, 30, 1, 0, 10, 0, 50, 5};

   initial begin
      int base, waited, p_done, p_rdy, c, r;
      rst_n = 1'b0;
      bus.i_mode = 1'b0; bus.i_start = 1'b0; bus.i_dec_ready = 1'b0;
      bus.i_dec_done = 1'b0; bus.i_dec_fail = 1'b0; bus.i_dec_metric = '0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      check("rst_busy", bus.o_busy, 0);
      check("rst_issue", bus.o_tp_issue, 0);
      check("rst_sel", bus.o_sel_valid, 0);
      check("rst_timeout", bus.o_timeout, 0);

      // Soft mode: four back-to-back issues, tie on 25 resolves to ID 2.
      bus.i_dec_ready = 1'b1;
      start_job(1'b1);
      for (int i = 1; i <= 4; i++) begin
         check("t1_issue", bus.o_tp_issue, 1);
         check("t1_id", bus.o_tp_id, i);
         tick();
      end
      do_done(1'b0, 12'd40);
      do_done(1'b0, 12'd25);
      do_done(1'b1, 12'd3);
      do_done(1'b0, 12'd25);
      expect_sel("t1", 2, 1'b0);
      tick();
      check("t1_pulse_width", bus.o_sel_valid, 0);

      // Hard mode: one pattern only.
      start_job(1'b0);
      check("t2_id", bus.o_tp_id, 1);
      tick();
      check("t2_single_issue", bus.o_tp_issue, 0);
      do_done(1'b0, 12'd7);
      expect_sel("t2", 1, 1'b0);
      tick();

      // Every pattern uncorrectable.
      start_job(1'b1);
      repeat (4) tick();
      for (int i = 0; i < 4; i++) do_done(1'b1, 12'($urandom));
      expect_sel("t3", 1, 1'b1);
      tick();

      // Spurious idle done, then ready toggling with dones overlapping issues.
      base = obs_sel_cnt;
      do_done(1'b0, 12'd3);
      check("t4_idle_done", bus.o_busy, 0);
      start_job(1'b1);
      for (int i = 0; i < 8; i++) begin
         bus.i_dec_ready = rdy4[i][0];
         if (dn4[i] != 0) do_done(1'b0, 12'(met4[i]));
         else tick();
      end
      bus.i_dec_ready = 1'b1;
      expect_sel("t4", 4, 1'b0);
      repeat (3) tick();
      check("t4_one_sel", obs_sel_cnt - base, 1);

      // Watchdog: results 2..4 withheld.
      base = obs_sel_cnt;
      start_job(1'b1);
      repeat (4) tick();
      do_done(1'b0, 12'd9);
      waited = 0;
      while (bus.o_sel_valid !== 1'b1 && waited < TO + 10) begin
         tick();
         waited++;
      end
      check("t5_to_latency", cyc - done_cyc, TO + 1);
      check("t5_timeout", bus.o_timeout, 1);
      check("t5_id", bus.o_select_tp, 1);
      check("t5_allfail", bus.o_all_fail, 0);
      tick();
      do_done(1'b0, 12'd1);
      repeat (2) tick();
      check("t5_late_ignored", obs_sel_cnt - base, 1);
      check("t5_sticky", bus.o_timeout, 1);

      // Reset while waiting aborts the job.
      base = obs_sel_cnt;
      start_job(1'b1);
      repeat (4) tick();
      do_done(1'b0, 12'd3);
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("t6_busy", bus.o_busy, 0);
      check("t6_timeout", bus.o_timeout, 0);
      repeat (5) tick();
      check("t6_no_stale", obs_sel_cnt - base, 0);
      start_job(1'b1);
      repeat (4) tick();
      for (int i = 0; i < 4; i++) do_done(1'b0, 12'd8);
      expect_sel("t6", 1, 1'b0);
      tick();

`ifdef TP_EARLY_EXIT_EN
      start_job(1'b1);
      tick();
      do_done(1'b0, 12'd0);
      check("ee_stopped", bus.o_tp_issue, 0);
      do_done(1'b0, 12'd3);
      expect_sel("ee", 1, 1'b0);
      tick();
`endif

      // Randomized jobs, including spurious starts/dones and occasional resets.
      for (int j = 0; j < 300; j++) begin
         r = $urandom_range(0, 2);
         p_done = (r == 0) ? 50 : ((r == 1) ? 15 : 2);
         p_rdy = $urandom_range(30, 100);
         start_job(1'($urandom));
         c = 0;
         while (m_active && c < 1000) begin
            bus.i_dec_ready  = ($urandom_range(0, 99) < p_rdy);
            bus.i_dec_done   = ($urandom_range(0, 99) < p_done);
            bus.i_dec_fail   = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 7);
            bus.i_dec_metric = (r == 0) ? '1 : ((r < 4) ? 12'(r - 1) : 12'($urandom));
            bus.i_start      = ($urandom_range(0, 49) == 0);
            bus.i_mode       = 1'($urandom);
            rst_n            = ($urandom_range(0, 399) != 0);
            tick();
            c++;
         end
         rst_n = 1'b1; bus.i_start = 1'b0; bus.i_dec_done = 1'b0;
         tick();
         check("rand_job_ended", bus.o_busy, 0);
      end

      repeat (3) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/chase_tp_scheduler.md
Name: chase_tp_scheduler

Overview:
Sequences Chase test patterns (TP1..TP4) through the shared BM/Chien decode pipeline and picks the winning pattern. In soft mode it issues each test pattern in turn and collects each per-pattern result (fail flag plus correlation metric). It then emits the winning pattern ID with a one-cycle valid pulse, which drives err_bit_saver_select_tp and err_bit_saver_valid_pulse downstream. In hard mode it issues a single pattern and reports pattern 1.

Parameters:
NUM_TP, 4, test patterns issued in soft mode (1..4)
METRIC_W, 12, width of the per-pattern correlation metric
TO_CYCLES, 1024, watchdog limit in cycles with no decoder progress while results are outstanding

Ports:
i_clk  input  1  clock
i_rst_n  input  1  reset; synchronous, active-low
i_mode  input  1  0 = hard (1 pattern), 1 = soft (NUM_TP patterns); sampled at i_start
i_start  input  1  pulse; codeword loaded, begin scheduling
o_busy  output  1  high from the cycle after an accepted i_start until the cycle after o_sel_valid
o_tp_issue  output  1  request to the decoder to start the pattern on o_tp_id
o_tp_id  output  3  pattern ID 1..NUM_TP, valid with o_tp_issue
i_dec_ready  input  1  decoder accepts an issue this cycle
i_dec_done  input  1  pulse; one result returned; results return in issue order
i_dec_fail  input  1  with i_dec_done: the pattern is uncorrectable
i_dec_metric  input  METRIC_W  with i_dec_done: correlation cost, lower is better
o_select_tp  output  3  winning pattern ID, valid with o_sel_valid
o_sel_valid  output  1  one-cycle pulse
o_all_fail  output  1  with o_sel_valid: every pattern failed or timed out
o_timeout  output  1  sticky until the next accepted i_start: watchdog fired

Behaviour:
- Reset: FSM to IDLE. All outputs 0. Counters 0. best_metric set to all-ones, best_id to 0.
- FSM states: IDLE, ISSUE, WAIT, DECIDE.
- IDLE: an i_start pulse latches n_tp (1 if i_mode = 0, else NUM_TP), clears issued, returned, best and o_timeout, then moves to ISSUE. i_start in any other state is ignored.
- ISSUE:
  - o_tp_issue = 1 and o_tp_id = issued + 1.
  - An issue is accepted on a cycle where o_tp_issue & i_dec_ready; that increments issued.
  - Back-to-back issues are allowed, so multiple patterns may be outstanding.
  - Moves to WAIT once issued reaches n_tp.
- i_dec_done is accepted in both ISSUE and WAIT, including the same cycle as an issue acceptance; that is not a conflict.
- On each accepted i_dec_done:
  - returned increments; result ID = returned + 1.
  - If !i_dec_fail and i_dec_metric < best_metric (strictly less), best updates to this result.
  - Ties keep the lower ID.
- i_dec_done with no outstanding pattern (returned == issued) is ignored and changes no state.
- WAIT: moves to DECIDE once returned == n_tp.
- DECIDE, one cycle:
  - o_sel_valid = 1 and o_select_tp = best_id.
  - If best_id == 0, o_select_tp = 1 and o_all_fail = 1.
  - Then returns to IDLE.
- Latency:
  - i_start at cycle t gives the first o_tp_issue at t+1.
  - The final accepted i_dec_done at cycle u gives o_sel_valid at u+1.
- Watchdog:
  - The counter clears on any accepted issue or done, and counts while issued > returned.
  - Reaching TO_CYCLES: set o_timeout, treat all remaining patterns as failed, go to DECIDE.
  - Late i_dec_done pulses are then ignored.
- Metric compare is unsigned, METRIC_W bits. An all-ones metric that does not fail is never selected; such a result alone gives o_all_fail = 1.
- Reset asserted in any state aborts the job. No o_sel_valid is produced for the aborted job.

Optional Feature:
TP_EARLY_EXIT_EN
- Defined:
  - An accepted, non-failed result with i_dec_metric == 0 stops further issues and forces that result to be best.
  - The block still waits until returned == issued, discarding later results, then goes to DECIDE.
- Undefined: all n_tp patterns are always issued and compared.

Test Plan:
- Soft mode, i_dec_ready = 1; metrics 40, 25, fail, 25 -> issues with IDs 1, 2, 3, 4 on consecutive cycles; o_select_tp = 2 (tie resolves to the lower ID); o_all_fail = 0; o_sel_valid exactly 1 cycle after the 4th done.
- Hard mode; single done with metric 7 -> only ID 1 issued; o_select_tp = 1 one cycle after the done.
- Soft mode, all four results fail -> o_select_tp = 1 and o_all_fail = 1.
- i_dec_ready toggling 1/0, done coinciding with an issue, plus a spurious done while idle -> issued and returned counts are correct; spurious done has no effect; exactly one o_sel_valid.
- Second done withheld for TO_CYCLES -> o_timeout = 1; selection made from result 1 only; a late done is ignored.
- Synchronous reset mid-WAIT, then a new i_start -> no stale o_sel_valid; o_timeout clear. Separately, with TP_EARLY_EXIT_EN defined, metric 0 on TP1 -> at most the already-issued patterns drain; o_select_tp = 1.
